inertial_integrator: RTL and testbench

//  Pitch-estimation stage feeding the PID controller. Takes raw gyro pitch rate and Z-accel samples from the

---
 rtl/inertial_integrator_if.sv | 32 +++
 rtl/inertial_integrator.sv | 162 ++++++++++++++++
 tb/tb_inertial_integrator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/inertial_integrator_if.sv
// ============================================================================
// Module   : inertial_integrator_if
// Purpose  : Sample/strobe bundle between the inertial front end and the
//            pitch integrator; modports for the driver and the integrator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inertial_integrator_if;
    logic        vld;
    logic [15:0] ptch_rt_raw;
    logic [15:0] AZ;
    logic        cal_start;
    logic        rider_off;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        ptch_vld;
    logic        cal_busy;
    logic        cal_done;

    modport master (
        output vld, ptch_rt_raw, AZ, cal_start, rider_off,
        input  ptch, ptch_rt, ptch_vld, cal_busy, cal_done
    );

    modport slave (
        input  vld, ptch_rt_raw, AZ, cal_start, rider_off,
        output ptch, ptch_rt, ptch_vld, cal_busy, cal_done
    );
endinterface

`default_nettype wire

// File: rtl/inertial_integrator.sv
// ============================================================================
// Module   : inertial_integrator
// Purpose  : Gyro offset removal, pitch integration with accel fusion and
//            gyro-offset calibration averaging 2^CAL_LOG2 samples.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inertial_integrator #(
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
    parameter int          CAL_LOG2       = 4,
    parameter int          FUSION_INC     = 1024
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    inertial_integrator_if.slave  bus
);

    localparam int                          c_ACC_W = 16 + CAL_LOG2;
    localparam int                          c_CNT_W = CAL_LOG2 + 1;
    localparam logic [c_CNT_W-1:0]          c_CAL_N = c_CNT_W'(2 ** CAL_LOG2);
    localparam logic signed [26:0]          c_FUS   = 27'(FUSION_INC);
    localparam logic signed [25:0]          c_GAIN  = 26'sd327;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_CAL = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic signed [26:0]         r_ptch_int;
    logic        [15:0]         r_ptch_rt;
    logic                       r_ptch_vld;
    logic                       r_cal_done;
    logic        [15:0]         r_offset;
    logic        [c_ACC_W-1:0]  r_cal_acc;
    logic        [c_CNT_W-1:0]  r_cal_cnt;

    logic        [15:0]         w_rt_comp;
    logic        [15:0]         w_az_comp;
    logic signed [25:0]         w_az_ext;
    logic signed [25:0]         w_prod;
    logic signed [15:0]         w_ptch_acc;
    logic signed [15:0]         w_ptch;
    logic signed [26:0]         w_fus;
    logic signed [26:0]         w_rt_ext;
    logic signed [26:0]         w_int_nxt;
    logic        [c_ACC_W-1:0]  w_acc_nxt;
    logic        [c_CNT_W-1:0]  w_cnt_nxt;
    logic        [15:0]         w_ofs_cal;
    logic                       w_integrate;
    logic                       w_acc_clr;
    logic                       w_acc_add;
    logic                       w_cal_fin;
    logic                       w_unused;

    // Datapath: offset removal, accel pitch estimate and fusion direction
    assign w_rt_comp  = bus.ptch_rt_raw - r_offset;
    assign w_az_comp  = bus.AZ - AZ_OFFSET;
    assign w_az_ext   = {{10{w_az_comp[15]}}, w_az_comp};
    assign w_prod     = w_az_ext * c_GAIN;
    assign w_ptch_acc = {{3{w_prod[25]}}, w_prod[25:13]};
    assign w_ptch     = r_ptch_int[26:11];
    assign w_fus      = (w_ptch_acc > w_ptch) ? c_FUS : -c_FUS;
    assign w_rt_ext   = {{11{w_rt_comp[15]}}, w_rt_comp};
    assign w_int_nxt  = r_ptch_int - w_rt_ext + w_fus;

    // Low 16 bits of (acc >>> CAL_LOG2) are simply the slice starting at CAL_LOG2
    assign w_acc_nxt  = r_cal_acc + {{CAL_LOG2{bus.ptch_rt_raw[15]}}, bus.ptch_rt_raw};
    assign w_cnt_nxt  = r_cal_cnt + c_CNT_W'(1);
    assign w_ofs_cal  = w_acc_nxt[CAL_LOG2 +: 16];

    assign w_unused   = &{1'b0, w_prod[12:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_integrate = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_add   = 1'b0;
        w_cal_fin   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.cal_start) begin
                    w_state_nxt = ST_CAL;
                    w_acc_clr   = 1'b1;
                end else if (bus.vld) begin
                    w_integrate = 1'b1;
                end
            end
            ST_CAL: begin
                if (bus.cal_start) begin
                    w_acc_clr = 1'b1;
                end else if (bus.vld) begin
                    w_acc_add = 1'b1;
                    if (w_cnt_nxt == c_CAL_N) begin
                        w_cal_fin   = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch_int <= '0;
            r_ptch_rt  <= '0;
            r_ptch_vld <= 1'b0;
            r_cal_done <= 1'b0;
            r_offset   <= PTCH_RT_OFFSET;
            r_cal_acc  <= '0;
            r_cal_cnt  <= '0;
        end else begin
            r_ptch_vld <= w_integrate;
            r_cal_done <= w_cal_fin;

            if (w_integrate) begin
                r_ptch_rt <= w_rt_comp;
            end

            // rider_off keeps the integrator pinned at zero regardless of state
            if (bus.rider_off || w_cal_fin) begin
                r_ptch_int <= '0;
            end else if (w_integrate) begin
                r_ptch_int <= w_int_nxt;
            end

            if (w_acc_clr) begin
                r_cal_acc <= '0;
                r_cal_cnt <= '0;
            end else if (w_acc_add) begin
                r_cal_acc <= w_acc_nxt;
                r_cal_cnt <= w_cnt_nxt;
            end

            if (w_cal_fin) begin
                r_offset <= w_ofs_cal;
            end
        end
    end

    assign bus.ptch     = w_ptch;
    assign bus.ptch_rt  = r_ptch_rt;
    assign bus.ptch_vld = r_ptch_vld;
    assign bus.cal_busy = (r_state == ST_CAL);
    assign bus.cal_done = r_cal_done;

endmodule

`default_nettype wire

// File: tb/tb_inertial_integrator.sv
// ============================================================================
// Module   : tb_inertial_integrator
// Purpose  : Directed self-checking bench for inertial_integrator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inertial_integrator;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    inertial_integrator_if bus ();

    inertial_integrator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle vld strobe; returns on the negedge one clock after the strobe edge
    task automatic send(input logic [15:0] raw);
        @(negedge clk);
        bus.vld         = 1'b1;
        bus.ptch_rt_raw = raw;
        @(negedge clk);
        bus.vld         = 1'b0;
    endtask

    task automatic start_cal(input logic with_vld, input logic [15:0] raw);
        @(negedge clk);
        bus.cal_start   = 1'b1;
        bus.vld         = with_vld;
        bus.ptch_rt_raw = raw;
        @(negedge clk);
        bus.cal_start   = 1'b0;
        bus.vld         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.vld         = 1'b0;
        bus.ptch_rt_raw = 16'h0000;
        bus.AZ          = 16'h00A0;
        bus.cal_start   = 1'b0;
        bus.rider_off   = 1'b0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_ptch",     bus.ptch,              16'h0000);
        chk("rst_ptch_rt",  bus.ptch_rt,           16'h0000);
        chk("rst_ptch_vld", 16'(bus.ptch_vld),     16'h0000);
        chk("rst_cal_busy", 16'(bus.cal_busy),     16'h0000);
        chk("rst_cal_done", 16'(bus.cal_done),     16'h0000);
        rst_n = 1'b1;

        send(16'h0050);
        chk("first_ptch_rt",  bus.ptch_rt,          16'h0000);
        chk("first_ptch_vld", 16'(bus.ptch_vld),    16'h0001);
        send(16'h0060);
        chk("rt_nonzero",     bus.ptch_rt,          16'h0010);

        // ---- latency and level: AZ at offset -> ptch dithers at 0/-1 ----
        for (int i = 0; i < 100; i++) begin
            send(16'h0050);
            chk("lat_vld_hi", 16'(bus.ptch_vld), 16'h0001);
            chk("lat_level", 16'((bus.ptch == 16'h0000) || (bus.ptch == 16'hFFFF)), 16'h0001);
            @(negedge clk);
            chk("lat_vld_lo", 16'(bus.ptch_vld), 16'h0000);
        end

        // ---- fusion convergence: +1024 per vld, ptch=floor(k/2) until 327 ----
        do_reset();
        bus.AZ = 16'h20A0;
        for (int i = 0; i < 653; i++) send(16'h0050);
        chk("fus_653", bus.ptch, 16'd326);
        send(16'h0050);
        chk("fus_654", bus.ptch, 16'd327);
        send(16'h0050);
        chk("fus_655", bus.ptch, 16'd326);
        for (int i = 0; i < 10; i++) begin
            send(16'h0050);
            chk("fus_band", 16'((bus.ptch == 16'd326) || (bus.ptch == 16'd327)), 16'h0001);
        end

        // ---- rider_off clears integrator, ptch_rt/ptch_vld still update ----
        @(negedge clk);
        bus.rider_off = 1'b1;
        @(negedge clk);
        chk("rider_clr", bus.ptch, 16'h0000);
        send(16'h0060);
        chk("rider_hold",  bus.ptch,           16'h0000);
        chk("rider_vld",   16'(bus.ptch_vld),  16'h0001);
        chk("rider_rt",    bus.ptch_rt,        16'h0010);
        bus.rider_off = 1'b0;
        bus.AZ        = 16'h00A0;

        // ---- calibration with raw=0x0123 ----
        start_cal(1'b0, 16'h0000);
        chk("cal_busy", 16'(bus.cal_busy), 16'h0001);
        for (int i = 0; i < 15; i++) begin
            send(16'h0123);
            chk("cal_no_vld",  16'(bus.ptch_vld), 16'h0000);
            chk("cal_no_done", 16'(bus.cal_done), 16'h0000);
        end
        chk("cal_rt_hold", bus.ptch_rt, 16'h0010);
        send(16'h0123);
        chk("cal_done",      16'(bus.cal_done), 16'h0001);
        chk("cal_busy_drop", 16'(bus.cal_busy), 16'h0000);
        @(negedge clk);
        chk("cal_done_pulse", 16'(bus.cal_done), 16'h0000);
        send(16'h0123);
        chk("cal_rt_zero", bus.ptch_rt, 16'h0000);
        chk("cal_ptch_vld", 16'(bus.ptch_vld), 16'h0001);

        // ---- calibration with negative samples ----
        start_cal(1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) send(16'hFFF0);
        chk("neg_done", 16'(bus.cal_done), 16'h0001);
        send(16'hFFF0);
        chk("neg_rt_zero", bus.ptch_rt, 16'h0000);
        send(16'h0000);
        chk("neg_ofs", bus.ptch_rt, 16'h0010);

        // ---- restart after 8 samples; coincident vld must not count ----
        start_cal(1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) send(16'h0400);
        start_cal(1'b1, 16'h0400);
        for (int i = 0; i < 15; i++) send(16'h0010);
        chk("rs_not_done", 16'(bus.cal_done), 16'h0000);
        chk("rs_busy",     16'(bus.cal_busy), 16'h0001);
        send(16'h0010);
        chk("rs_done", 16'(bus.cal_done), 16'h0001);
        send(16'h0010);
        chk("rs_rt_zero", bus.ptch_rt, 16'h0000);

        // ---- async reset mid-calibration restores the default offset ----
        start_cal(1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) send(16'h0200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 16'(bus.cal_busy), 16'h0000);
        chk("mid_rst_rt",   bus.ptch_rt,       16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0050);
        chk("mid_rst_ofs", bus.ptch_rt, 16'h0000);
        send(16'h0000);
        chk("mid_rst_ofs2", bus.ptch_rt, 16'hFFB0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
